// File: rtl/fft8_frame_sequencer.sv
// Serial-to-frame sequencer for the 8-point FFT core.
// Fills one frame while the previous one computes and drains.
module fft8_frame_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_real,
  input  logic [DATA_W-1:0]   s_imag,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_real,
  output logic [DATA_W-1:0]   m_imag,
  output logic                m_last,
  output logic [8*DATA_W-1:0] core_in_real,
  output logic [8*DATA_W-1:0] core_in_imag,
  output logic                core_write,
  input  logic                core_ready,
  input  logic [8*DATA_W-1:0] core_out_real,
  input  logic [8*DATA_W-1:0] core_out_imag,
  output logic [15:0]         frame_count,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t state, nxt;

  logic [DATA_W-1:0] in_re  [8];
  logic [DATA_W-1:0] in_im  [8];
  logic [DATA_W-1:0] out_re [8];
  logic [DATA_W-1:0] out_im [8];

  logic [2:0]    in_idx, out_idx;
  logic          buf_full, out_busy;
  logic [CW-1:0] cnt;
  logic          s_hs, m_hs, last_hs, out_free;
  logic          cap, tmo, cnt_inc;

  assign s_ready  = !buf_full;
  assign s_hs     = s_valid & s_ready;
  assign m_valid  = out_busy;
  assign m_hs     = m_valid & m_ready;
  assign m_last   = out_busy & (out_idx == 3'd7);
  assign last_hs  = m_hs & (out_idx == 3'd7);
  // a frame finishing this cycle frees out_buf for a same-cycle capture
  assign out_free = !out_busy | last_hs;
  assign m_real   = out_re[out_idx];
  assign m_imag   = out_im[out_idx];

  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign core_in_real[k*DATA_W +: DATA_W] = in_re[k];
    assign core_in_imag[k*DATA_W +: DATA_W] = in_im[k];
  end

  always_comb begin
    nxt        = state;
    core_write = 1'b0;
    cap        = 1'b0;
    tmo        = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (buf_full) nxt = S_WRITE;
      end
      S_WRITE: begin
        core_write = 1'b1;
        nxt        = S_WAIT;
      end
      S_WAIT: begin
        // first WAIT cycle still shows the previous frame's ready
        if (cnt != '0 && core_ready) begin
          if (out_free) begin
            cap = 1'b1;
            nxt = S_IDLE;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo = 1'b1;
          nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_WRITE) cnt <= '0;
      else if (cnt_inc)     cnt <= cnt + CW'(1);
      if (tmo) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_idx   <= '0;
      buf_full <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        in_re[k] <= '0;
        in_im[k] <= '0;
      end
    end else begin
      if (s_hs) begin
        in_re[in_idx] <= s_real;
        in_im[in_idx] <= s_imag;
        in_idx        <= in_idx + 3'd1;
        if (in_idx == 3'd7) buf_full <= 1'b1;
      end
      if (state == S_WRITE) buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx     <= '0;
      out_busy    <= 1'b0;
      frame_count <= '0;
      for (int k = 0; k < 8; k++) begin
        out_re[k] <= '0;
        out_im[k] <= '0;
      end
    end else begin
      if (m_hs) begin
        out_idx <= out_idx + 3'd1;
        if (out_idx == 3'd7) begin
          out_busy    <= 1'b0;
          frame_count <= frame_count + 16'd1;
        end
      end
      if (cap) begin
        out_busy <= 1'b1;
        out_idx  <= '0;
        for (int k = 0; k < 8; k++) begin
          out_re[k] <= core_out_real[k*DATA_W +: DATA_W];
          out_im[k] <= core_out_imag[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Bench for fft8_frame_sequencer: mock DFT core plus
// a frame-level scoreboard of input frames and output bins.
module tb_fft8_frame_sequencer;

  localparam int W  = 16;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready;
  logic [W-1:0]     s_real, s_imag;
  logic             m_valid, m_ready, m_last;
  logic [W-1:0]     m_real, m_imag;
  logic [8*W-1:0]   core_in_real, core_in_imag;
  logic             core_write;
  logic             core_ready = 1'b0;
  logic [8*W-1:0]   core_out_real = '0;
  logic [8*W-1:0]   core_out_imag = '0;
  logic [15:0]      frame_count;
  logic             timeout_err;

  always #5 clk = ~clk;

  fft8_frame_sequencer #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_real(m_real), .m_imag(m_imag), .m_last(m_last),
    .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_write(core_write), .core_ready(core_ready),
    .core_out_real(core_out_real), .core_out_imag(core_out_imag),
    .frame_count(frame_count), .timeout_err(timeout_err)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [8*W-1:0] got,
                     input logic [8*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd(input real v);
    int i;
    if (v >= 0.0) i = $rtoi(v + 0.5);
    else          i = -$rtoi(0.5 - v);
    return i[W-1:0];
  endfunction

  // exact 8-point DFT, rounded; result packed {imag, real}
  function automatic logic [16*W-1:0] dft8(input logic [8*W-1:0] xr,
                                           input logic [8*W-1:0] xi);
    logic [16*W-1:0] y;
    real sr, si, a, vr, vi;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        a  = -2.0 * 3.141592653589793 * real'(k * n) / 8.0;
        vr = real'($signed(xr[n*W +: W]));
        vi = real'($signed(xi[n*W +: W]));
        sr = sr + vr * $cos(a) - vi * $sin(a);
        si = si + vr * $sin(a) + vi * $cos(a);
      end
      y[k*W +: W]     = rnd(sr);
      y[(8+k)*W +: W] = rnd(si);
    end
    return y;
  endfunction

  // mock core: ready stays high with the old result for one
  // cycle after a load, new result appears 3 cycles after it
  logic [16*W-1:0] pend = '0;
  int              age  = 0;
  bit              never = 1'b0;

  always @(posedge clk) begin
    if (core_write) begin
      pend <= dft8(core_in_real, core_in_imag);
      age  <= 1;
    end else if (age == 1) begin
      core_ready <= 1'b0;
      age        <= 2;
    end else if (age == 2) begin
      age <= 0;
      if (!never) begin
        core_ready    <= 1'b1;
        core_out_real <= pend[8*W-1:0];
        core_out_imag <= pend[16*W-1:8*W];
      end
    end
  end

  // scoreboard state
  logic [8*W-1:0] fq_r [$];
  logic [8*W-1:0] fq_i [$];
  logic [W-1:0]   exp_r [$];
  logic [W-1:0]   exp_i [$];
  logic [W-1:0]   last_r [8];
  logic [W-1:0]   last_i [8];
  logic [8*W-1:0] cur_r, cur_i;
  int             cur_n, nbin, fdone, writes;
  bit             mfull;
  bit             pv, prdy;
  logic [W-1:0]   pr, pi;

  initial begin
    logic [8*W-1:0] fr, fi;
    logic [16*W-1:0] y;
    cur_n = 0; nbin = 0; fdone = 0; writes = 0;
    mfull = 0; pv = 0; prdy = 0; pr = '0; pi = '0;
    cur_r = '0; cur_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fq_r.delete(); fq_i.delete();
        exp_r.delete(); exp_i.delete();
        cur_n = 0; nbin = 0; fdone = 0;
        mfull = 0; pv = 0;
      end else begin
        chk("s_ready", s_ready, !mfull);
        if (pv && !prdy)
          chk("m_hold", {m_valid, m_real, m_imag}, {1'b1, pr, pi});
        if (core_write) begin
          writes++;
          chk("write_pending", fq_r.size(), 1);
          if (fq_r.size() != 0) begin
            fr = fq_r.pop_front();
            fi = fq_i.pop_front();
            chk("core_in_re", core_in_real, fr);
            chk("core_in_im", core_in_imag, fi);
            if (!never) begin
              y = dft8(fr, fi);
              for (int k = 0; k < 8; k++) begin
                exp_r.push_back(y[k*W +: W]);
                exp_i.push_back(y[(8+k)*W +: W]);
              end
            end
          end
          mfull = 0;
        end
        if (s_valid && s_ready) begin
          cur_r[cur_n*W +: W] = s_real;
          cur_i[cur_n*W +: W] = s_imag;
          cur_n++;
          if (cur_n == 8) begin
            fq_r.push_back(cur_r);
            fq_i.push_back(cur_i);
            cur_n = 0;
            mfull = 1;
          end
        end
        if (m_valid && m_ready) begin
          if (exp_r.size() == 0) begin
            chk("bin_extra", m_valid, 1'b0);
          end else begin
            chk("bin_re", m_real, exp_r.pop_front());
            chk("bin_im", m_imag, exp_i.pop_front());
            chk("m_last", m_last, nbin == 7);
            last_r[nbin] = m_real;
            last_i[nbin] = m_imag;
            nbin = (nbin + 1) % 8;
            if (nbin == 0) fdone++;
          end
        end
        pv = m_valid; prdy = m_ready; pr = m_real; pi = m_imag;
      end
    end
  end

  int mrmode = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mrmode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'b0;
        3: m_ready = 1'($urandom_range(1));
        default: ;
      endcase
    end
  end

  task automatic send(input logic [8*W-1:0] fr, input logic [8*W-1:0] fi,
                      input int n, input int gap);
    int b;
    bit hs;
    for (int k = 0; k < n; k++) begin
      if (gap > 0 && int'($urandom_range(99)) < gap) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_real  = fr[k*W +: W];
      s_imag  = fi[k*W +: W];
      b = 0;
      hs = 1'b0;
      while (!hs && b < 300) begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk);
        #1;
        b++;
      end
      chk("s_handshake", hs, 1'b1);
    end
    s_valid = 1'b0;
  endtask

  task automatic rand_frame(output logic [8*W-1:0] fr,
                            output logic [8*W-1:0] fi);
    int v;
    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(8000)) - 4000;
      fr[k*W +: W] = v[W-1:0];
      v = int'($urandom_range(8000)) - 4000;
      fi[k*W +: W] = v[W-1:0];
    end
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    while (b < 3000 &&
           (exp_r.size() != 0 || fq_r.size() != 0 || mfull)) begin
      @(posedge clk);
      #1;
      b++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(tag, b < 3000, 1'b1);
  endtask

  initial begin
    logic [8*W-1:0] fr, fi;
    int w0, n, b;
    bit mv_seen;
    rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_cwrite", core_write, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sready", s_ready, 1'b1);
    chk("rst_mlast", m_last, 1'b0);
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_core_in", core_in_real, '0);

    // impulse
    fr = '0; fi = '0;
    fr[W-1:0] = 16'd100;
    w0 = writes;
    send(fr, fi, 8, 0);
    drain("imp_drain");
    chk("imp_writes", writes - w0, 1);
    chk("imp_fc", frame_count, 16'd1);
    for (int k = 0; k < 8; k++) begin
      chk("imp_bin", {last_r[k], last_i[k]}, {16'd100, 16'd0});
    end

    // DC
    for (int k = 0; k < 8; k++) begin
      fr[k*W +: W] = 16'd10;
      fi[k*W +: W] = 16'hFFFB;
    end
    send(fr, fi, 8, 0);
    drain("dc_drain");
    chk("dc_bin0", {last_r[0], last_i[0]}, {16'd80, 16'hFFD8});
    for (int k = 1; k < 8; k++) begin
      chk("dc_bin", {last_r[k], last_i[k]}, '0);
    end
    chk("dc_fc", frame_count, 16'd2);

    // back-to-back with toggling backpressure
    mrmode = 1;
    for (int f = 0; f < 3; f++) begin
      rand_frame(fr, fi);
      send(fr, fi, 8, 0);
    end
    drain("ovl_drain");
    chk("ovl_fc", frame_count, 16'd5);

    // long output stall with next frame computed and a third waiting
    mrmode = 2;
    @(posedge clk);
    #1;
    w0 = writes;
    for (int f = 0; f < 3; f++) begin
      rand_frame(fr, fi);
      send(fr, fi, 8, 0);
    end
    repeat (40) @(posedge clk);
    #1;
    chk("stall_writes", writes - w0, 2);
    chk("stall_mvalid", m_valid, 1'b1);
    chk("stall_sready", s_ready, 1'b0);
    chk("stall_cready", core_ready, 1'b1);
    mrmode = 0;
    drain("stall_drain");
    chk("stall_fc", frame_count, 16'd8);
    chk("stall_writes2", writes - w0, 3);

    // core never responds
    never = 1'b1;
    rand_frame(fr, fi);
    send(fr, fi, 8, 0);
    b = 0;
    while (!core_write && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("to_write_seen", core_write, 1'b1);
    n = 0;
    mv_seen = 1'b0;
    while (!timeout_err && n < 100) begin
      @(negedge clk);
      n++;
      if (m_valid) mv_seen = 1'b1;
    end
    chk("to_latency", n, TO + 1);
    chk("to_no_mvalid", mv_seen, 1'b0);
    @(posedge clk);
    #1;
    never = 1'b0;
    chk("to_fc", frame_count, 16'd8);
    rand_frame(fr, fi);
    send(fr, fi, 8, 0);
    drain("to_drain");
    chk("to_fc2", frame_count, 16'd9);
    chk("to_sticky", timeout_err, 1'b1);

    // reset in the middle of a fill
    rand_frame(fr, fi);
    send(fr, fi, 5, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ra_sready", s_ready, 1'b1);
    chk("ra_mvalid", m_valid, 1'b0);
    chk("ra_fc", frame_count, 16'd0);
    chk("ra_terr", timeout_err, 1'b0);
    chk("ra_core_in", core_in_real, '0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // reset while bin 3 is presented
    mrmode = 4;
    m_ready = 1'b0;
    rand_frame(fr, fi);
    send(fr, fi, 8, 0);
    b = 0;
    while (!m_valid && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("rb_mvalid", m_valid, 1'b1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rb_mvalid0", m_valid, 1'b0);
    chk("rb_mlast", m_last, 1'b0);
    chk("rb_mreal", m_real, '0);
    chk("rb_fc", frame_count, 16'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mrmode = 0;
    rand_frame(fr, fi);
    send(fr, fi, 8, 0);
    drain("rb_drain");
    chk("rb_fc2", frame_count, 16'd1);

    // random gaps and backpressure
    mrmode = 3;
    for (int f = 0; f < 10; f++) begin
      rand_frame(fr, fi);
      send(fr, fi, 8, 30);
    end
    drain("rnd_drain");
    chk("rnd_fc", frame_count, 16'(fdone));
    chk("rnd_fc_abs", frame_count, 16'd11);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
- Sequencer in front of the 8-point FFT core (parallel 8×complex in/out, write-load and ready handshake).
- Converts a serial valid/ready complex sample stream into 8-sample frames, issues the core load, waits for core ready with timeout, captures the result, and streams it out serially.
- Input fill of frame N+1 overlaps the core compute and output drain of frame N.

Parameters:
DATA_W, 16, width of each real/imag component (signed)
TIMEOUT, 15, max cycles in WAIT before core_ready must be seen (≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&s_ready
s_real  in  DATA_W  input sample real
s_imag  in  DATA_W  input sample imag
m_valid  out  1  output bin valid
m_ready  in  1  downstream accept
m_real  out  DATA_W  output bin real
m_imag  out  DATA_W  output bin imag
m_last  out  1  high with bin 7
core_in_real  out  8*DATA_W  sample k at [k*DATA_W +: DATA_W]
core_in_imag  out  8*DATA_W  same packing
core_write  out  1  one-cycle load pulse to core
core_ready  in  1  core result valid
core_out_real  in  8*DATA_W  bin k at [k*DATA_W +: DATA_W]
core_out_imag  in  8*DATA_W  same packing
frame_count  out  16  frames delivered (m_last handshakes), wraps at 2^16
timeout_err  out  1  sticky: core_ready not seen within TIMEOUT

Behaviour:
- Reset (async, any state): FSM=IDLE; in_idx=0, buf_full=0, out_busy=0, out_idx=0, frame_count=0, timeout_err=0; s_ready=1 after reset deasserts; m_valid=0, m_last=0, core_write=0; buffers cleared to 0. Reset mid-frame discards all partial data.
- Input side: s_ready = !buf_full. Each handshake writes in_buf[in_idx], in_idx++ (natural order). Handshake at in_idx=7 sets buf_full, in_idx wraps to 0.
- core_in_real/imag driven continuously from in_buf.
- FSM (registered state):
  IDLE: buf_full=1 -> WRITE.
  WRITE: core_write=1 for exactly this cycle; buf_full clears at end of cycle (s_ready high next cycle); wait counter=0 -> WAIT.
  WAIT: counter++ each cycle; core_ready ignored in first WAIT cycle (core ready still reflects previous frame). From 2nd cycle, core_ready=1 and out_busy=0 -> capture core_out into out_buf, out_busy=1, -> IDLE. core_ready=1 with out_busy=1 -> stay in WAIT (counter frozen) until out_busy clears. Counter reaching TIMEOUT with no core_ready -> timeout_err=1, frame dropped, -> IDLE.
- Capture is allowed in the same cycle as the final output handshake (bin 7 accepted): zero-bubble back-to-back frames.
- Output side: m_valid=out_busy; m_real/m_imag=out_buf[out_idx]; m_last=out_busy&(out_idx==7). On handshake out_idx++; on bin-7 handshake out_idx=0, out_busy=0, frame_count++. m_valid never drops while out_busy without a handshake; data stable while m_valid&!m_ready.
- Min latency: 8th input handshake at cycle t -> core_write at t+2 -> capture earliest t+4 (core-dependent) -> m_valid bin 0 next cycle.
- No arithmetic in this block; data passed bit-exact. Ordering: natural in, natural out (bit reversal owned by core).
- timeout_err cleared only by rst.

Test Plan:
- Impulse: samples x0=(100,0), x1..x7=0, mock core computing exact DFT with ready 3 cycles after write -> 8 bins each (100,0), m_last only on 8th, frame_count=1, core_write exactly one pulse.
- DC: all 8 samples (10,-5) -> bin0=(80,-40), bins1..7=(0,0); check core_in packing sample k at slice k.
- Overlap/backpressure: 3 frames back-to-back with s_valid=1, m_ready toggling 1/0 every cycle -> all 24 bins correct in order, no drop/duplication, s_ready low only while buf_full, frame_count=3.
- Stall: m_ready=0 for 40 cycles during frame 1 with frame 2 computed -> FSM holds in WAIT, core_ready high ignored for capture, frame 2 bins emitted correctly after release.
- Timeout: mock core never asserts ready -> timeout_err=1 exactly TIMEOUT(15) cycles into WAIT, no m_valid, next frame with working core delivers normally, timeout_err stays 1.
- Reset mid-operation: assert rst after 5 samples and again while m_valid with out_idx=3 -> all outputs return to reset values immediately (async), next full frame processed from sample 0 correctly.
